// File: rtl/lbp_stream_if.sv
// Host-side bus of the LBP streaming engine: gray-frame read port, LBP result
// write port, quasi-static configuration and a debug view of the control FSM.
interface lbp_stream_if #(
  parameter int ADDR_W = 14,
  parameter int PIX_W  = 8
);
  // Read handshake: a read issues in every cycle where gray_req && gray_ready
  // are both high; gray_data carries that read's pixel exactly one cycle later,
  // whatever gray_ready does in that next cycle. lbp_valid is a one-cycle write
  // strobe with no back-pressure.
  logic              gray_ready;
  logic              gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic [PIX_W-1:0]  gray_data;
  logic              lbp_mode;
  logic [PIX_W-1:0]  lbp_thr;
  logic [ADDR_W-1:0] lbp_addr;
  logic              lbp_valid;
  logic [7:0]        lbp_data;
  logic              finish;
  logic [1:0]        dbg_state;

  modport master (
    input  gray_ready, gray_data, lbp_mode, lbp_thr,
    output gray_req, gray_addr, lbp_addr, lbp_valid, lbp_data, finish, dbg_state
  );

  modport slave (
    output gray_ready, gray_data, lbp_mode, lbp_thr,
    input  gray_req, gray_addr, lbp_addr, lbp_valid, lbp_data, finish, dbg_state
  );
endinterface

// File: rtl/lbp_stream.sv
// Streaming 3x3 LBP engine: reads a frame once in raster order through two
// line buffers and a 3x3 window, writing one code per interior pixel.
module lbp_stream #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
  input  logic         clk,
  input  logic         reset,
  lbp_stream_if.master bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [ADDR_W-1:0] CTR_OFS   = ADDR_W'(IMG_W + 1);
  localparam logic [CW-1:0]     LAST_COL  = CW'(IMG_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic              gray_req_q;
  logic [ADDR_W-1:0] gray_addr_q;
  logic              finish_q;
  logic              issue;

  logic              s_vld;
  logic              last_wr;
  logic [CW-1:0]     smp_c;
  logic [RW-1:0]     smp_r;
  logic [ADDR_W-1:0] smp_idx;

  logic [PIX_W-1:0]  win [3][2];
  logic [PIX_W-1:0]  lb1 [IMG_W];
  logic [PIX_W-1:0]  lb2 [IMG_W];
  logic [PIX_W-1:0]  lb1_rd;
  logic [PIX_W-1:0]  lb2_rd;
  logic              win_full;

  logic              lbp_valid_q;
  logic [ADDR_W-1:0] lbp_addr_q;
  logic [7:0]        lbp_data_q;

  logic [PIX_W-1:0]  nbr [8];
  logic [PIX_W:0]    ref_v;
  logic [7:0]        bits;
  logic [7:0]        ring;
  logic [3:0]        ones;
  logic [3:0]        trans;
  logic [7:0]        code;

  assign issue    = (state == READ) && gray_req_q && bus.gray_ready;
  assign lb1_rd   = lb1[smp_c];
  assign lb2_rd   = lb2[smp_c];
  assign win_full = (smp_r >= RW'(2)) && (smp_c >= CW'(2));

  assign bus.gray_req  = gray_req_q;
  assign bus.gray_addr = gray_addr_q;
  assign bus.lbp_valid = lbp_valid_q;
  assign bus.lbp_addr  = lbp_addr_q;
  assign bus.lbp_data  = lbp_data_q;
  assign bus.finish    = finish_q;
  assign bus.dbg_state = state;

  // Request is the registered copy of gray_ready while reading; the final
  // address is issued once and then the request drops for good.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      gray_req_q  <= 1'b0;
      gray_addr_q <= '0;
      finish_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.gray_ready) begin
            state      <= READ;
            gray_req_q <= 1'b1;
          end
        end
        READ: begin
          gray_req_q <= bus.gray_ready;
          if (issue) begin
            if (gray_addr_q == LAST_ADDR) begin
              state      <= DRAIN;
              gray_req_q <= 1'b0;
            end else begin
              gray_addr_q <= gray_addr_q + ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          if (last_wr) begin
            state    <= DONE;
            finish_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Line buffers are pure storage: rows r-1 and r-2 at the current column.
  always_ff @(posedge clk) begin
    if (s_vld) begin
      lb1[smp_c] <= bus.gray_data;
      lb2[smp_c] <= lb1_rd;
    end
  end

  // Window columns are refilled at c=0 and c=1 before any code uses them, so
  // stale columns from the previous row never reach the comparator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_vld       <= 1'b0;
      last_wr     <= 1'b0;
      smp_c       <= '0;
      smp_r       <= '0;
      smp_idx     <= '0;
      lbp_valid_q <= 1'b0;
      lbp_addr_q  <= '0;
      lbp_data_q  <= '0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 2; j++) begin
          win[i][j] <= '0;
        end
      end
    end else begin
      s_vld       <= issue;
      lbp_valid_q <= 1'b0;
      last_wr     <= 1'b0;
      if (s_vld) begin
        win[0][0] <= win[0][1];
        win[0][1] <= lb2_rd;
        win[1][0] <= win[1][1];
        win[1][1] <= lb1_rd;
        win[2][0] <= win[2][1];
        win[2][1] <= bus.gray_data;
        if (smp_c == LAST_COL) begin
          smp_c <= '0;
          smp_r <= smp_r + RW'(1);
        end else begin
          smp_c <= smp_c + CW'(1);
        end
        smp_idx <= smp_idx + ADDR_W'(1);
        if (win_full) begin
          lbp_valid_q <= 1'b1;
          lbp_addr_q  <= smp_idx - CTR_OFS;
          lbp_data_q  <= code;
        end
        if (smp_idx == LAST_ADDR) begin
          last_wr <= 1'b1;
        end
      end
    end
  end

  // Code of the window completed by the incoming sample; the threshold sum
  // carries one extra bit so a saturated centre never wraps.
  always_comb begin
    nbr[0] = win[0][0];
    nbr[1] = win[0][1];
    nbr[2] = lb2_rd;
    nbr[3] = win[1][0];
    nbr[4] = lb1_rd;
    nbr[5] = win[2][0];
    nbr[6] = win[2][1];
    nbr[7] = bus.gray_data;
    ref_v  = {1'b0, win[1][1]} + {1'b0, bus.lbp_thr};
    bits   = '0;
    for (int i = 0; i < 8; i++) begin
      bits[i] = ({1'b0, nbr[i]} >= ref_v);
    end
    ring  = {bits[3], bits[5], bits[6], bits[7], bits[4], bits[2], bits[1], bits[0]};
    ones  = '0;
    trans = '0;
    for (int i = 0; i < 8; i++) begin
      ones  = ones + 4'(bits[i]);
      trans = trans + 4'(ring[i] ^ ring[(i + 1) % 8]);
    end
    if (bus.lbp_mode) begin
      code = (trans <= 4'd2) ? {4'd0, ones} : 8'd9;
    end else begin
      code = bits;
    end
  end

endmodule
